// File: rtl/pram_dual_port.sv
// rtl/pram_dual_port.sv - true dual-port RAM, 1-cycle write-first reads, port 1 wins write-write collisions
// `define PRAM_INIT_CLEAR_EN adds a post-reset sweep that zeroes memory through port 1's write path.
module pram_dual_port #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [WIDTH-1:0]  data1,
  input  logic [WIDTH-1:0]  data2,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic              ready,
  output logic              collision
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  out1_q, out1_d, out2_q, out2_d;
  logic              ready_q, collision_q, collision_d;
  logic              same_addr, wr_coll;
  logic              p1_we, p2_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [WIDTH-1:0]  p1_data;

`ifdef PRAM_INIT_CLEAR_EN
  typedef enum logic {S_INIT, S_READY} state_t;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
  state_t          state_q;
  logic [ADDR_W:0] clr_ptr_q;
`endif

  always_comb begin
    same_addr   = (addr1 == addr2);
    wr_coll     = we1 && we2 && same_addr;
    collision_d = ready_q && wr_coll;
    // Write-first read data; port 1 data dominates any same-address write.
    if (we1)                 out1_d = data1;
    else if (we2 && same_addr) out1_d = data2;
    else                     out1_d = mem[addr1];
    if (we1 && same_addr)    out2_d = data1;
    else if (we2)            out2_d = data2;
    else                     out2_d = mem[addr2];
    p1_we   = !reset && ready_q && we1;
    p1_addr = addr1;
    p1_data = data1;
    p2_we   = !reset && ready_q && we2 && !wr_coll;
`ifdef PRAM_INIT_CLEAR_EN
    if (!reset && state_q == S_INIT) begin
      p1_we   = 1'b1;
      p1_addr = clr_ptr_q[ADDR_W-1:0];
      p1_data = '0;
    end
`endif
  end

  // Storage has no reset so it maps onto the hard dual-port RAM.
  always_ff @(posedge clock) begin
    if (p1_we) mem[p1_addr] <= p1_data;
    if (p2_we) mem[addr2]   <= data2;
  end

`ifdef PRAM_INIT_CLEAR_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_INIT;
      clr_ptr_q   <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
      ready_q     <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          clr_ptr_q   <= clr_ptr_q + 1'b1;
          out1_q      <= '0;
          out2_q      <= '0;
          collision_q <= 1'b0;
          if (clr_ptr_q == LAST_ADDR) begin
            state_q <= S_READY;
            ready_q <= 1'b1;
          end
        end
        default: begin
          out1_q      <= out1_d;
          out2_q      <= out2_d;
          collision_q <= collision_d;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      out1_q      <= '0;
      out2_q      <= '0;
      ready_q     <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      ready_q     <= 1'b1;
      collision_q <= collision_d;
      if (ready_q) begin
        out1_q <= out1_d;
        out2_q <= out2_d;
      end else begin
        out1_q <= '0;
        out2_q <= '0;
      end
    end
  end
`endif

  assign out1      = out1_q;
  assign out2      = out2_q;
  assign ready     = ready_q;
  assign collision = collision_q;
endmodule

// File: tb/tb_pram_dual_port.sv
// tb/tb_pram_dual_port.sv - scoreboard bench for pram_dual_port, both PRAM_INIT_CLEAR_EN builds
module tb_pram_dual_port;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       we1 = 1'b0, we2 = 1'b0;
  logic [2:0] addr1 = '0, addr2 = '0;
  logic [7:0] data1 = '0, data2 = '0;
  logic [7:0] out1, out2;
  logic       ready, collision;

  typedef struct {
    logic [7:0] o1;
    logic [7:0] o2;
    logic       coll;
  } want_t;

  want_t      sb[$];
  logic [7:0] model [8];
  int         n_tests = 0;
  int         n_fail  = 0;

  pram_dual_port #(.WIDTH(8), .ADDR_W(3)) dut (
    .clock(clock), .reset(reset), .we1(we1), .we2(we2),
    .addr1(addr1), .addr2(addr2), .data1(data1), .data2(data2),
    .out1(out1), .out2(out2), .ready(ready), .collision(collision)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One READY-state access: model the write-first result, enqueue, clock, dequeue and compare.
  task automatic cycle(input string tag, input logic w1, input logic [2:0] a1, input logic [7:0] d1,
                       input logic w2, input logic [2:0] a2, input logic [7:0] d2);
    want_t w;
    we1 = w1; addr1 = a1; data1 = d1;
    we2 = w2; addr2 = a2; data2 = d2;
    if (w2) model[a2] = d2;
    if (w1) model[a1] = d1;
    w.o1 = model[a1];
    w.o2 = model[a2];
    w.coll = w1 && w2 && (a1 == a2);
    sb.push_back(w);
    tick();
    we1 = 1'b0; we2 = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      w = sb.pop_front();
      chk({tag, "_out1"}, {24'd0, out1}, {24'd0, w.o1});
      chk({tag, "_out2"}, {24'd0, out2}, {24'd0, w.o2});
      chk({tag, "_coll"}, {31'd0, collision}, {31'd0, w.coll});
    end
  endtask

  initial begin
    int first;
    tick(); tick();
    chk("rst_ready", {31'd0, ready}, 0);
    chk("rst_out1", {24'd0, out1}, 0);
    chk("rst_out2", {24'd0, out2}, 0);
    chk("rst_coll", {31'd0, collision}, 0);

`ifdef PRAM_INIT_CLEAR_EN
    // Sweep interrupted at clr_ptr = 4, with a write attempt that must be ignored.
    reset = 1'b0;
    we1 = 1'b1; addr1 = 3'd1; data1 = 8'hFF;
    for (int i = 0; i < 4; i++) tick();
    chk("init_ready_mid", {31'd0, ready}, 0);
    chk("init_out1_mid", {24'd0, out1}, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    we1 = 1'b1; addr1 = 3'd6; data1 = 8'hEE;
    first = 0;
    for (int n = 1; n <= 20 && first == 0; n++) begin
      tick();
      if (ready) first = n;
    end
    we1 = 1'b0;
    chk("init_ready_edges", first, 8);
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    for (int i = 0; i < 8; i++) cycle("clear_read", 1'b0, 3'(i), 8'h00, 1'b0, 3'(7 - i), 8'h00);
`else
    reset = 1'b0;
    we1 = 1'b1; addr1 = 3'd1; data1 = 8'hFF;
    tick();
    we1 = 1'b0;
    chk("ready_one_edge", {31'd0, ready}, 1);
    for (int i = 0; i < 8; i++) cycle("preload", 1'b1, 3'(i), 8'(i * 13 + 1), 1'b0, 3'(i), 8'h00);
    cycle("pre77", 1'b1, 3'd7, 8'h77, 1'b0, 3'd0, 8'h00);
    reset = 1'b1;
    tick();
    chk("pulse_ready", {31'd0, ready}, 0);
    chk("pulse_out1", {24'd0, out1}, 0);
    reset = 1'b0;
    tick();
    chk("pulse_ready_back", {31'd0, ready}, 1);
    cycle("persist7", 1'b0, 3'd7, 8'h00, 1'b0, 3'd7, 8'h00);
`endif

    cycle("w3", 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00);
    cycle("r3", 1'b0, 3'd3, 8'h00, 1'b0, 3'd3, 8'h00);
    cycle("ww5", 1'b1, 3'd5, 8'h11, 1'b1, 3'd5, 8'h22);
    cycle("after_ww5", 1'b0, 3'd5, 8'h00, 1'b0, 3'd5, 8'h00);
    cycle("wr2", 1'b1, 3'd2, 8'h3C, 1'b0, 3'd2, 8'h00);
    cycle("rw4", 1'b0, 3'd4, 8'h00, 1'b1, 3'd4, 8'h9D);
    cycle("diff", 1'b1, 3'd0, 8'h5A, 1'b1, 3'd7, 8'hC3);
    cycle("diff_rd", 1'b0, 3'd7, 8'h00, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 60; i++) begin
      cycle("rand", 1'($urandom), 3'($urandom_range(0, 3)), 8'($urandom),
                    1'($urandom), 3'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pram_dual_port.md
# pram_dual_port

Parametrised true dual-port RAM controller with synchronous 1-cycle reads and write-first behaviour on both ports. Same-address write-write collisions are resolved with port 1 priority and flagged. An optional post-reset clearing sweep is included. It replaces fixed-width direct dual-port RAM instantiations in benchmark top levels and maps onto the architecture's dual-port hard RAM plus soft control logic.

## Interface
- WIDTH, 8, data bit width per word (≥1)
- ADDR_W, 3, address bits; DEPTH = 2**ADDR_W words (≥1)
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- we1  input  1  port 1 write enable
- we2  input  1  port 2 write enable
- addr1  input  ADDR_W  port 1 address
- addr2  input  ADDR_W  port 2 address
- data1  input  WIDTH  port 1 write data
- data2  input  WIDTH  port 2 write data
- out1  output  WIDTH  port 1 registered read data
- out2  output  WIDTH  port 2 registered read data
- ready  output  1  high when user accesses are accepted
- collision  output  1  one-cycle pulse: both ports wrote the same address

## Operation
- States: INIT (clearing sweep), READY. A `clr_ptr` counter of ADDR_W+1 bits is used during INIT.
- Reset (sampled high) forces:
  - state INIT, clr_ptr = 0
  - out1 = out2 = 0, ready = 0, collision = 0
  - memory contents are not reset by the reset itself.
- INIT, each edge with reset low:
  - write 0 to mem[clr_ptr], then clr_ptr++.
  - On the edge that clears address DEPTH-1: state goes to READY and ready = 1.
  - In INIT, we1/we2/addr/data are ignored. out1, out2 and collision hold 0.
- READY, each edge:
  - Port write: if weN, mem[addrN] ← dataN.
  - Port read: outN ← contents of addrN *after* this edge's writes (write-first; cross-port write-through included).
  - Write-write, addr1 == addr2, we1 = we2 = 1: port 1 data is stored and port 2 data is dropped. out1 = out2 = data1. collision = 1 for exactly that cycle.
  - Writes to different addresses on the same edge both commit. collision = 0.
  - Read on one port and write on the other, same address: the reader gets the new data. collision = 0.
- Reset asserted mid-INIT or mid-READY: takes effect on that edge with no partial behaviour. The sweep restarts from 0.

## Timing
- Read latency: 1 cycle. Address presented at edge N gives data on outN after edge N.
- Write visible to either port's read on the same edge (write-first).
- ready rises exactly DEPTH edges after the first edge with reset low (PRAM_INIT_CLEAR_EN defined). It stays high until the next reset.
- collision is registered and high for the single cycle following the offending edge. It is 0 in all other cycles.
- Address and data must be stable at the clock edge only. There is no handshake beyond ready; accesses while ready = 0 are silently discarded.

## Configuration
- Macro: `PRAM_INIT_CLEAR_EN`.
- Defined:
  - INIT sweep as above. Memory reads 0 everywhere once ready = 1.
  - Clearing uses port 1's write path only.
- Undefined:
  - No INIT state and no clr_ptr.
  - Reset sets ready = 0; ready = 1 on the first edge with reset low.
  - Memory contents persist across reset. Contents are undefined after power-up.

## Test plan
- Macro on, DEPTH=8. Release reset, then read all addresses → ready low for exactly 8 edges, then high; out1 = out2 = 0x00 for addresses 0–7.
- Port 1 writes 0xA5 to address 3. Next cycle, port 2 reads address 3 → out1 = 0xA5 and out2 = 0xA5, each one cycle after its access.
- Both ports write address 5 in the same cycle, data1 = 0x11, data2 = 0x22 → collision = 1 for one cycle; out1 = out2 = 0x11. A later read of address 5 returns 0x11.
- Same cycle: port 1 writes 0x3C to address 2; port 2 reads address 2 with we2 = 0 → out2 = 0x3C next cycle; collision = 0.
- Assert reset for one cycle while clr_ptr = 4 in INIT; attempt a write with we1 = 1 during INIT → ready stays low for 8 full edges after release. The ignored write leaves its address at 0x00.
- Macro off. Preload address 7 with 0x77, pulse reset → ready high one edge after release; a read of address 7 returns 0x77.
